// File: rtl/merlin_bus_arbiter.sv
// rtl/merlin_bus_arbiter.sv - two-to-one instruction/data arbiter onto one memory port with in-order response routing
module merlin_bus_arbiter #(
    parameter int C_OST_DEPTH_X = 2,
    parameter int C_DSTREAK_MAX = 4
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        clk_en_i,

    output logic        ireqready_o,
    input  logic        ireqvalid_i,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,

    input  logic        irspready_i,
    output logic        irspvalid_o,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,

    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqsize_i,
    input  logic        dreqdvalid_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,

    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o,

    input  logic        mreqready_i,
    output logic        mreqvalid_o,
    output logic [1:0]  mreqsize_o,
    output logic        mreqwr_o,
    output logic [1:0]  mreqhpl_o,
    output logic [31:0] mreqaddr_o,
    output logic [31:0] mreqdata_o,

    output logic        mrspready_o,
    input  logic        mrspvalid_i,
    input  logic        mrsprerr_i,
    input  logic        mrspwerr_i,
    input  logic [31:0] mrspdata_i
);

    localparam int LP_DEPTH = 1 << C_OST_DEPTH_X;
    localparam int LP_SW    = ($clog2(C_DSTREAK_MAX + 1) > 3) ? $clog2(C_DSTREAK_MAX + 1) : 3;
    localparam logic [LP_SW-1:0]         LP_SMAX = LP_SW'(C_DSTREAK_MAX);
    localparam logic [C_OST_DEPTH_X:0]   LP_FULL = (C_OST_DEPTH_X + 1)'(LP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [LP_SW-1:0]         r_streak;
    logic [LP_DEPTH-1:0]      r_route;
    logic [C_OST_DEPTH_X-1:0] r_wptr;
    logic [C_OST_DEPTH_X-1:0] r_rptr;
    logic [C_OST_DEPTH_X:0]   r_count;

    logic w_gnt_i;
    logic w_gnt_d;
    logic w_req_valid;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_fifo_full  = (r_count == LP_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_route[r_rptr];

    // A locked state presents only its own port; IDLE picks data first unless the instruction side has waited too long.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        case (r_state)
            ST_LOCK_I: w_gnt_i = 1'b1;
            ST_LOCK_D: w_gnt_d = 1'b1;
            default: begin
                if (dreqvalid_i && !(ireqvalid_i && (r_streak == LP_SMAX))) begin
                    w_gnt_d = 1'b1;
                end else if (ireqvalid_i) begin
                    w_gnt_i = 1'b1;
                end
            end
        endcase
    end

    assign w_req_valid = (w_gnt_i & ireqvalid_i) | (w_gnt_d & dreqvalid_i);
    assign mreqvalid_o = w_req_valid & ~w_fifo_full & clk_en_i & resetb_i;
    assign w_accept    = mreqvalid_o & mreqready_i;
    assign w_push      = w_accept;
    assign ireqready_o = mreqready_i & w_gnt_i & ~w_fifo_full & clk_en_i & resetb_i;
    assign dreqready_o = mreqready_i & w_gnt_d & ~w_fifo_full & clk_en_i & resetb_i;

    always_comb begin
        mreqsize_o = 2'b00;
        mreqwr_o   = 1'b0;
        mreqhpl_o  = 2'b00;
        mreqaddr_o = '0;
        mreqdata_o = '0;
        if (w_gnt_d) begin
            mreqsize_o = dreqsize_i;
            mreqwr_o   = dreqdvalid_i;
            mreqhpl_o  = dreqhpl_i;
            mreqaddr_o = dreqaddr_i;
            mreqdata_o = dreqdata_i;
        end else if (w_gnt_i) begin
            mreqsize_o = 2'b10;
            mreqhpl_o  = ireqhpl_i;
            mreqaddr_o = ireqaddr_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mreqvalid_o && !mreqready_i) begin
                    w_state_nxt = w_gnt_d ? ST_LOCK_D : ST_LOCK_I;
                end
            end
            ST_LOCK_I: begin
                if (w_accept || !ireqvalid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCK_D: begin
                if (w_accept || !dreqvalid_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Response steering follows the oldest outstanding route; an empty FIFO ignores the memory side entirely.
    assign mrspready_o = ~w_fifo_empty & clk_en_i & (w_head ? drspready_i : irspready_i);
    assign w_pop       = mrspvalid_i & mrspready_o;
    assign irspvalid_o = mrspvalid_i & ~w_fifo_empty & ~w_head & clk_en_i;
    assign drspvalid_o = mrspvalid_i & ~w_fifo_empty & w_head & clk_en_i;
    assign irsprerr_o  = mrsprerr_i;
    assign drsprerr_o  = mrsprerr_i;
    assign drspwerr_o  = mrspwerr_i;
    assign irspdata_o  = mrspdata_i;
    assign drspdata_o  = mrspdata_i;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state  <= ST_IDLE;
            r_streak <= '0;
            r_route  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (w_gnt_d && ireqvalid_i) begin
                    if (r_streak != LP_SMAX) begin
                        r_streak <= r_streak + 1'b1;
                    end
                end else begin
                    r_streak <= '0;
                end
            end
            if (w_push) begin
                r_route[r_wptr] <= w_gnt_d;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_merlin_bus_arbiter.sv
// tb/tb_merlin_bus_arbiter.sv - scoreboard bench for merlin_bus_arbiter
module tb_merlin_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetb_i, clk_en_i;
    logic        ireqready_o, ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspready_i, irspvalid_o, irsprerr_o;
    logic [31:0] irspdata_o;
    logic        dreqready_o, dreqvalid_i, dreqdvalid_i;
    logic [1:0]  dreqsize_i, dreqhpl_i;
    logic [31:0] dreqaddr_i, dreqdata_i;
    logic        drspready_i, drspvalid_o, drsprerr_o, drspwerr_o;
    logic [31:0] drspdata_o;
    logic        mreqready_i, mreqvalid_o, mreqwr_o;
    logic [1:0]  mreqsize_o, mreqhpl_o;
    logic [31:0] mreqaddr_o, mreqdata_o;
    logic        mrspready_o, mrspvalid_i, mrsprerr_i, mrspwerr_i;
    logic [31:0] mrspdata_i;

    merlin_bus_arbiter #(.C_OST_DEPTH_X(2), .C_DSTREAK_MAX(4)) u_dut (
        .clk_i(clk), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
        .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i), .ireqaddr_i(ireqaddr_i),
        .irspready_i(irspready_i), .irspvalid_o(irspvalid_o), .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
        .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqsize_i(dreqsize_i), .dreqdvalid_i(dreqdvalid_i),
        .dreqhpl_i(dreqhpl_i), .dreqaddr_i(dreqaddr_i), .dreqdata_i(dreqdata_i),
        .drspready_i(drspready_i), .drspvalid_o(drspvalid_o), .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o),
        .drspdata_o(drspdata_o),
        .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqsize_o(mreqsize_o), .mreqwr_o(mreqwr_o),
        .mreqhpl_o(mreqhpl_o), .mreqaddr_o(mreqaddr_o), .mreqdata_o(mreqdata_o),
        .mrspready_o(mrspready_o), .mrspvalid_i(mrspvalid_i), .mrsprerr_i(mrsprerr_i), .mrspwerr_i(mrspwerr_i),
        .mrspdata_i(mrspdata_i)
    );

    typedef struct packed { logic port; logic [31:0] addr; logic wr; } req_t;
    typedef struct packed { logic port; logic [31:0] data; } rsp_t;

    req_t        exp_req[$];
    rsp_t        mem_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] next_data;
    bit          rsp_en;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic p, input logic [31:0] a, input logic w);
        req_t e;
        e.port = p;
        e.addr = a;
        e.wr   = w;
        exp_req.push_back(e);
    endtask

    // Memory model presents the oldest pending response, then outputs settle.
    task automatic settle();
        if (rsp_en) begin
            if (mem_q.size() > 0) begin
                mrspvalid_i = 1'b1;
                mrspdata_i  = mem_q[0].data;
                mrsprerr_i  = mem_q[0].data[0];
            end else begin
                mrspvalid_i = 1'b0;
            end
        end
        #1;
    endtask

    task automatic adv();
        req_t e;
        rsp_t m;
        if (mreqvalid_o && mreqready_i) begin
            if (exp_req.size() == 0) begin
                check_eq("req_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_req.pop_front();
                check_eq("req_port", {31'd0, dreqready_o}, {31'd0, e.port});
                check_eq("req_addr", mreqaddr_o, e.addr);
                check_eq("req_wr", {31'd0, mreqwr_o}, {31'd0, e.wr});
                m.port = e.port;
                m.data = next_data;
                next_data = next_data + 32'd1;
                mem_q.push_back(m);
            end
        end
        if (mrspvalid_i && mrspready_o) begin
            if (mem_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                m = mem_q.pop_front();
                check_eq("rsp_dvalid", {31'd0, drspvalid_o}, {31'd0, m.port});
                check_eq("rsp_ivalid", {31'd0, irspvalid_o}, {31'd0, ~m.port});
                check_eq("rsp_data", m.port ? drspdata_o : irspdata_o, m.data);
                check_eq("rsp_rerr", {31'd0, m.port ? drsprerr_o : irsprerr_o}, {31'd0, m.data[0]});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ia, da, ia_e, da_e;
        logic        ii, di;
        logic        t_port [4];
        logic [31:0] t_addr [4];
        int          n;

        resetb_i = 1'b0; clk_en_i = 1'b1;
        ireqvalid_i = 1'b1; ireqhpl_i = 2'b11; ireqaddr_i = 32'h0;
        irspready_i = 1'b1; drspready_i = 1'b1;
        dreqvalid_i = 1'b1; dreqdvalid_i = 1'b0; dreqsize_i = 2'b10; dreqhpl_i = 2'b01;
        dreqaddr_i = 32'h0; dreqdata_i = 32'h0;
        mreqready_i = 1'b1; mrspvalid_i = 1'b1; mrsprerr_i = 1'b0; mrspwerr_i = 1'b0; mrspdata_i = 32'h0;
        next_data = 32'h1000; rsp_en = 1'b0;

        @(negedge clk);
        #1;
        check_eq("rst_mreqvalid", {31'd0, mreqvalid_o}, 32'd0);
        check_eq("rst_ireqready", {31'd0, ireqready_o}, 32'd0);
        check_eq("rst_dreqready", {31'd0, dreqready_o}, 32'd0);
        check_eq("rst_mrspready", {31'd0, mrspready_o}, 32'd0);
        check_eq("rst_rspvalid", {30'd0, irspvalid_o, drspvalid_o}, 32'd0);
        @(negedge clk);
        resetb_i = 1'b1; ireqvalid_i = 1'b0; dreqvalid_i = 1'b0; mrspvalid_i = 1'b0;

        clk_en_i = 1'b0; dreqvalid_i = 1'b1; dreqaddr_i = 32'h600;
        settle();
        check_eq("cen_mreqvalid", {31'd0, mreqvalid_o}, 32'd0);
        check_eq("cen_dreqready", {31'd0, dreqready_o}, 32'd0);
        adv();
        clk_en_i = 1'b1; dreqvalid_i = 1'b0;

        // Both ports always valid: D,D,D,D,I repeating.
        rsp_en = 1'b1; ireqvalid_i = 1'b1; dreqvalid_i = 1'b1;
        ia = 32'h1000; da = 32'h2000; ia_e = ia; da_e = da;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin exp_push(1'b0, ia_e, 1'b0); ia_e = ia_e + 4; end
            else begin exp_push(1'b1, da_e, 1'b0); da_e = da_e + 4; end
        end
        for (int k = 0; k < 10; k++) begin
            ireqaddr_i = ia; dreqaddr_i = da;
            settle();
            ii = ireqready_o; di = dreqready_o;
            adv();
            if (ii) ia = ia + 4;
            if (di) da = da + 4;
        end
        ireqvalid_i = 1'b0; dreqvalid_i = 1'b0;
        repeat (3) begin settle(); adv(); end
        check_eq("seq_done", exp_req.size(), 32'd0);

        // Data grant held under back-pressure while instruction request arrives.
        mreqready_i = 1'b0; dreqvalid_i = 1'b1; dreqaddr_i = 32'h300; dreqdvalid_i = 1'b1;
        dreqdata_i = 32'h55; dreqsize_i = 2'b01;
        exp_push(1'b1, 32'h300, 1'b1); exp_push(1'b0, 32'h400, 1'b0);
        settle();
        check_eq("stall_valid", {31'd0, mreqvalid_o}, 32'd1);
        check_eq("stall_addr1", mreqaddr_o, 32'h300);
        adv();
        ireqvalid_i = 1'b1; ireqaddr_i = 32'h400;
        settle();
        check_eq("stall_addr2", mreqaddr_o, 32'h300);
        check_eq("stall_iready", {31'd0, ireqready_o}, 32'd0);
        check_eq("stall_data", mreqdata_o, 32'h55);
        adv();
        settle();
        check_eq("stall_addr3", mreqaddr_o, 32'h300);
        check_eq("stall_size", {30'd0, mreqsize_o}, 32'd1);
        adv();
        mreqready_i = 1'b1;
        settle();
        check_eq("stall_dready", {31'd0, dreqready_o}, 32'd1);
        adv();
        dreqvalid_i = 1'b0; dreqdvalid_i = 1'b0; dreqsize_i = 2'b10;
        settle();
        check_eq("stall_igrant", {31'd0, ireqready_o}, 32'd1);
        adv();
        ireqvalid_i = 1'b0;
        repeat (3) begin settle(); adv(); end

        // Fill to four outstanding, stall the fifth, then route responses in order.
        rsp_en = 1'b0; mrspvalid_i = 1'b0; next_data = 32'hA;
        t_port[0] = 1'b0; t_addr[0] = 32'h100;
        t_port[1] = 1'b1; t_addr[1] = 32'h200;
        t_port[2] = 1'b0; t_addr[2] = 32'h104;
        t_port[3] = 1'b1; t_addr[3] = 32'h208;
        for (int k = 0; k < 4; k++) begin
            ireqvalid_i = ~t_port[k]; dreqvalid_i = t_port[k];
            ireqaddr_i = t_addr[k]; dreqaddr_i = t_addr[k];
            exp_push(t_port[k], t_addr[k], 1'b0);
            settle();
            if (!t_port[k]) check_eq("ifetch_size", {30'd0, mreqsize_o}, 32'd2);
            adv();
        end
        dreqvalid_i = 1'b0; ireqvalid_i = 1'b1; ireqaddr_i = 32'h108;
        settle();
        check_eq("full_iready", {31'd0, ireqready_o}, 32'd0);
        check_eq("full_mvalid", {31'd0, mreqvalid_o}, 32'd0);
        adv();
        ireqvalid_i = 1'b0;
        rsp_en = 1'b1;
        settle(); adv();
        drspready_i = 1'b0;
        settle();
        check_eq("hold_mready", {31'd0, mrspready_o}, 32'd0);
        check_eq("hold_dvalid", {31'd0, drspvalid_o}, 32'd1);
        check_eq("hold_ivalid", {31'd0, irspvalid_o}, 32'd0);
        adv();
        drspready_i = 1'b1;
        settle(); adv();
        settle();
        check_eq("one_pop_ivalid", {31'd0, irspvalid_o}, 32'd1);
        check_eq("one_pop_data", irspdata_o, 32'hC);
        adv();
        settle(); adv();
        rsp_en = 1'b0; mrspvalid_i = 1'b1; mrspdata_i = 32'hEE;
        #1;
        check_eq("empty_mready", {31'd0, mrspready_o}, 32'd0);
        check_eq("empty_rspvalid", {30'd0, irspvalid_o, drspvalid_o}, 32'd0);
        check_eq("empty_memq", mem_q.size(), 32'd0);
        adv();
        mrspvalid_i = 1'b0;

        // Full FIFO: pop and new request in the same cycle; request waits one cycle.
        for (int k = 0; k < 4; k++) begin
            ireqvalid_i = 1'b1; ireqaddr_i = 32'h700 + 32'(4 * k);
            exp_push(1'b0, 32'h700 + 32'(4 * k), 1'b0);
            settle(); adv();
        end
        ireqaddr_i = 32'h800;
        exp_push(1'b0, 32'h800, 1'b0);
        rsp_en = 1'b1;
        settle();
        check_eq("popfull_iready", {31'd0, ireqready_o}, 32'd0);
        check_eq("popfull_mvalid", {31'd0, mreqvalid_o}, 32'd0);
        check_eq("popfull_mready", {31'd0, mrspready_o}, 32'd1);
        adv();
        settle();
        check_eq("popfull_next", {31'd0, ireqready_o}, 32'd1);
        adv();
        ireqvalid_i = 1'b0;
        n = 0;
        while (mem_q.size() > 0 && n < 20) begin settle(); adv(); n++; end
        check_eq("drain_memq", mem_q.size(), 32'd0);
        check_eq("drain_expq", exp_req.size(), 32'd0);

        // Asynchronous reset mid-stall with two routes outstanding.
        rsp_en = 1'b0; mrspvalid_i = 1'b0;
        dreqvalid_i = 1'b1; dreqaddr_i = 32'h900; exp_push(1'b1, 32'h900, 1'b0);
        settle(); adv();
        dreqvalid_i = 1'b0; ireqvalid_i = 1'b1; ireqaddr_i = 32'h904; exp_push(1'b0, 32'h904, 1'b0);
        settle(); adv();
        ireqvalid_i = 1'b0; mreqready_i = 1'b0; dreqvalid_i = 1'b1; dreqaddr_i = 32'h908;
        settle();
        check_eq("prerst_stall", {31'd0, mreqvalid_o}, 32'd1);
        mrspvalid_i = 1'b1;
        #1;
        resetb_i = 1'b0;
        #1;
        check_eq("arst_mvalid", {31'd0, mreqvalid_o}, 32'd0);
        check_eq("arst_ready", {30'd0, ireqready_o, dreqready_o}, 32'd0);
        check_eq("arst_mready", {31'd0, mrspready_o}, 32'd0);
        check_eq("arst_rspvalid", {30'd0, irspvalid_o, drspvalid_o}, 32'd0);
        @(negedge clk);
        dreqvalid_i = 1'b0; mem_q.delete(); resetb_i = 1'b1; mrspvalid_i = 1'b1;
        #1;
        check_eq("postrst_mready", {31'd0, mrspready_o}, 32'd0);
        check_eq("postrst_rspvalid", {30'd0, irspvalid_o, drspvalid_o}, 32'd0);
        @(negedge clk);
        mrspvalid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/merlin_bus_arbiter.md
# merlin_bus_arbiter

Two-to-one bus arbiter between the merlin32i core's instruction port and data port and a single shared memory port. Merges requests with data-priority arbitration and an instruction anti-starvation limit, and holds a grant stable while memory back-pressures. Tracks outstanding transactions in an in-order route FIFO and steers each memory response back to its originating port. Sits directly downstream of the core, between it and the memory/interconnect.

## Interface
- C_OST_DEPTH_X, 2, outstanding-transaction FIFO depth as a base-2 exponent (4 entries)
- C_DSTREAK_MAX, 4, maximum consecutive data grants while an instruction request waits
- clk_i  in  1  clock
- resetb_i  in  1  reset; one clock, asynchronous assert, active-low
- clk_en_i  in  1  clock enable; when low, state holds and all ready/valid outputs are 0
- ireqready_o / ireqvalid_i / ireqhpl_i[1:0] / ireqaddr_i[31:0]  out/in/in/in  instruction request
- irspready_i / irspvalid_o / irsprerr_o / irspdata_o[31:0]  in/out/out/out  instruction response
- dreqready_o / dreqvalid_i / dreqsize_i[1:0] / dreqdvalid_i / dreqhpl_i[1:0] / dreqaddr_i[31:0] / dreqdata_i[31:0]  out/in…  data request; dreqdvalid_i=1 means store
- drspready_i / drspvalid_o / drsprerr_o / drspwerr_o / drspdata_o[31:0]  in/out/out/out/out  data response
- mreqready_i  in  1  memory accepts request
- mreqvalid_o, mreqsize_o[1:0], mreqwr_o, mreqhpl_o[1:0], mreqaddr_o[31:0], mreqdata_o[31:0]  out  memory request
- mrspready_o  out  1  arbiter accepts response
- mrspvalid_i, mrsprerr_i, mrspwerr_i, mrspdata_i[31:0]  in  memory response

## Operation
- Grant FSM has three states: IDLE, LOCK_I, LOCK_D.
  - IDLE: chooses combinationally. Data wins if dreqvalid_i, unless ireqvalid_i and streak==C_DSTREAK_MAX, in which case instruction wins. Otherwise instruction wins if ireqvalid_i.
  - IDLE -> LOCK_x: taken when the chosen port presents mreqvalid_o and mreqready_i=0.
  - LOCK_x: only port x is presented. Returns to IDLE on acceptance, or if x drops valid.
- Accept = mreqvalid_o & mreqready_i. mreqvalid_o = granted valid & !fifo_full & clk_en_i & resetb_i.
- ireqready_o / dreqready_o = mreqready_i & grant==port & !fifo_full & clk_en_i.
- Instruction request fields on the memory port: mreqsize_o=2'b10, mreqwr_o=0, mreqdata_o=0.
- Data request fields on the memory port: mreqwr_o=dreqdvalid_i; size, addr, data and hpl pass through.
- Streak counter, 3+ bits, saturating:
  - increments on a data accept while ireqvalid_i=1;
  - clears on an instruction accept, or on a data accept while ireqvalid_i=0.
- Route FIFO: 2^C_OST_DEPTH_X entries × 1 bit (0=I, 1=D).
  - Push on accept. Pop on mrspvalid_i & mrspready_o.
  - Push is blocked when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: occupancy unchanged. Pointers wrap modulo depth.
- Response steering:
  - head=I: irspvalid_o=mrspvalid_i & !empty; mrspready_o=irspready_i.
  - head=D: drspvalid_o=mrspvalid_i & !empty; mrspready_o=drspready_i.
  - rerr, werr and data are broadcast to both ports; each port's valid qualifies them.
- Empty FIFO: mrspready_o=0, both response valids 0, and a spurious mrspvalid_i is ignored.

## Timing
- Request path is combinational, 0-cycle latency, memory-port input to core-port output. Response path is likewise 0-cycle.
- Grant FSM, streak counter and FIFO update on rising clk_i only when clk_en_i=1.
- Reset (async, resetb_i=0):
  - FSM=IDLE, streak=0, FIFO empty, pointers 0.
  - All valid and ready outputs are 0 while reset is asserted.
- Reset mid-transaction drops all outstanding routes. Responses arriving after reset release hit an empty FIFO and are ignored.
- A locked grant never changes while mreqvalid_o=1 and mreqready_i=0. Request fields are stable under stall.
- Max outstanding = 2^C_OST_DEPTH_X. The (N+1)th request is stalled until a response pops.

## Test plan
- Both valid every cycle, mreqready_i=1, responses returned immediately: grant sequence D,D,D,D,I,D,D,D,D,I; streak caps at 4.
- dreqvalid_i=1 with mreqready_i=0 for 3 cycles while ireqvalid_i rises in cycle 2: the D grant holds and address is stable, D is accepted in cycle 4, and I is granted next.
- Issue I@0x100, D-load@0x200, I@0x104, D@0x208 with no responses: the 5th request stalls (ready=0). Then 4 responses with data 0xA,0xB,0xC,0xD route to I,D,I,D in order, and the FIFO returns to empty.
- Head=D with drspready_i=0 and mrspvalid_i=1: mrspready_o=0, drspvalid_o=1, irspvalid_o=0. Raising drspready_i pops exactly one entry.
- Full FIFO with simultaneous pop and a new request in the same cycle: the request is not accepted that cycle and is accepted the next cycle.
- resetb_i pulsed low mid-stall with 2 outstanding: all outputs go to 0 asynchronously, and a post-reset mrspvalid_i=1 gives mrspready_o=0 with no core response.
